alu_multdiv_seq: RTL

- Multi-cycle signed multiply/divide sequencer that sits beside the 32-bit add/sub ALU in the execute stage.
- On a start pulse it latches the operands and runs 32 iterations of shift-add (multiply) or restoring shift-subtract (divide) through its internal 33-bit add/sub datapath.
- It then presents a 32-bit result with an exception flag and a one-cycle ready strobe.
- The pipeline stalls on `busy`.

---
 rtl/alu_multdiv_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/alu_multdiv_seq.sv
// alu_multdiv_seq: multi-cycle signed multiply / divide sequencer.
// Runs 32 iterations of shift-add (multiply) or restoring shift-subtract
// (divide) on operand magnitudes, then applies the sign fixup.
// Optional build macro MULTDIV_REMAINDER_EN adds the data_remainder output.
module alu_multdiv_seq #(
  parameter int ITER = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
`ifdef MULTDIV_REMAINDER_EN
  ,
  output logic [31:0] data_remainder
`endif
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_a;        // |A|: multiplicand
  logic [31:0]     r_b;        // |B|: divisor
  logic [31:0]     r_hi;       // accumulator high word / remainder
  logic [31:0]     r_lo;       // multiplier / quotient
  logic            r_sign;     // A[31]^B[31]
  logic [31:0]     r_result;
  logic            r_exc;
`ifdef MULTDIV_REMAINDER_EN
  logic            r_dsign;    // dividend sign
  logic [31:0]     r_rem;
  logic [31:0]     w_rem_fix;
`endif

  logic            w_start_mul;
  logic            w_start_div;
  logic            w_last;
  logic [31:0]     w_abs_a;
  logic [31:0]     w_abs_b;
  logic [32:0]     w_sum33;
  logic [32:0]     w_rem33;
  logic [32:0]     w_diff33;
  logic [31:0]     w_hi_nx;
  logic [31:0]     w_lo_nx;
  logic [63:0]     w_prod;
  logic [31:0]     w_quo;
  logic            w_mul_exc;
  logic            w_div_exc;

  assign w_start_mul = ctrl_MULT & ~ctrl_DIV;
  assign w_start_div = ctrl_DIV & ~ctrl_MULT;
  assign w_last      = (r_cnt == CW'(ITER - 1));
  assign w_abs_a     = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
  assign w_abs_b     = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = (r_state == S_DONE);
  assign busy           = (r_state == S_MUL) || (r_state == S_DIV);
`ifdef MULTDIV_REMAINDER_EN
  assign data_remainder = r_rem;
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  // Next-state logic; starts are only honoured in IDLE
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_mul)      w_state_nx = S_MUL;
        else if (w_start_div) w_state_nx = (data_operandB == '0) ? S_DONE : S_DIV;
      end
      S_MUL:   if (w_last) w_state_nx = S_DONE;
      S_DIV:   if (w_last) w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // One iteration of the 33-bit add/sub datapath plus final sign fixup.
  // The fixup is taken from the last iteration's value so the result is
  // already registered during the ready cycle.
  always_comb begin
    w_sum33  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : 33'd0);
    w_rem33  = {r_hi, r_lo[31]};
    w_diff33 = w_rem33 - {1'b0, r_b};
    w_hi_nx  = w_sum33[32:1];
    w_lo_nx  = {w_sum33[0], r_lo[31:1]};
    if (r_state == S_DIV) begin
      if (!w_diff33[32]) begin
        w_hi_nx = w_diff33[31:0];
        w_lo_nx = {r_lo[30:0], 1'b1};
      end else begin
        w_hi_nx = w_rem33[31:0];
        w_lo_nx = {r_lo[30:0], 1'b0};
      end
    end
    w_prod    = r_sign ? (~{w_hi_nx, w_lo_nx} + 64'd1) : {w_hi_nx, w_lo_nx};
    w_mul_exc = (w_prod[63:32] != {32{w_prod[31]}});
    w_quo     = r_sign ? (~w_lo_nx + 32'd1) : w_lo_nx;
    w_div_exc = ~r_sign & w_lo_nx[31];
`ifdef MULTDIV_REMAINDER_EN
    w_rem_fix = r_dsign ? (~w_hi_nx + 32'd1) : w_hi_nx;
`endif
  end

  // Operand latch, iteration registers and held result
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_sign   <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
      r_dsign  <= 1'b0;
      r_rem    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_mul || w_start_div) begin
            r_cnt  <= '0;
            r_a    <= w_abs_a;
            r_b    <= w_abs_b;
            r_hi   <= '0;
            r_lo   <= w_start_mul ? w_abs_b : w_abs_a;
            r_sign <= data_operandA[31] ^ data_operandB[31];
`ifdef MULTDIV_REMAINDER_EN
            r_dsign <= data_operandA[31];
`endif
            if (w_start_div && (data_operandB == '0)) begin
              r_result <= '0;
              r_exc    <= 1'b1;
`ifdef MULTDIV_REMAINDER_EN
              r_rem    <= data_operandA;
`endif
            end
          end
        end
        S_MUL, S_DIV: begin
          r_hi  <= w_hi_nx;
          r_lo  <= w_lo_nx;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            if (r_state == S_MUL) begin
              r_result <= w_prod[31:0];
              r_exc    <= w_mul_exc;
`ifdef MULTDIV_REMAINDER_EN
              r_rem    <= '0;
`endif
            end else begin
              r_result <= w_quo;
              r_exc    <= w_div_exc;
`ifdef MULTDIV_REMAINDER_EN
              r_rem    <= w_rem_fix;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
